hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard and forwarding unit for the in-order pipeline. It tracks in-flight register writes across a configurable number of post-decode stages in an internal scoreboard shift register. Each cycle it selects, for every ID-stage source operand, either the register file or the youngest in-flight producer. It stalls ID when a producer's data is not yet available, such as on load-use. It sits in ID, beside the register file and control-unit mux, and drives PC/IF_ID load-enable and bubble insertion.

## Interface
- DW, 32, operand data width
- RW, 4, register index width (2^RW architectural registers)
- STAGES, 3, in-flight stages tracked after ID (index 0 = EX, 1 = MEM, 2 = WB, ...)
- LOAD_READY, 1, first stage index whose stage_data carries a load's result
- clk  in  1  clock, rising edge
- R  in  1  reset; asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_flush  in  1  squash current ID instruction; it is not recorded
- id_rn, id_rm, id_rd  in  RW each  ID source indices (Rd used as store data)
- id_rn_used, id_rm_used, id_rd_used  in  1 each  source actually read
- id_wr_en  in  1  ID instruction writes a register
- id_wr_reg  in  RW  destination (already Rd-or-14 resolved)
- id_is_load  in  1  ID instruction is a load
- rf_pa, rf_pb, rf_pd  in  DW each  register file read ports
- stage_data  in  STAGES*DW  forwarded value per stage, stage k at [k*DW +: DW]
- op_a, op_b, op_d  out  DW each  forwarded operands
- fw_rn_sel, fw_rm_sel, fw_rd_sel  out  SELW each  0 = RF, k = stage k-1; SELW = $clog2(STAGES+1)
- stall  out  1  hold PC and IF_ID (LE = ~stall)
- bubble  out  1  select NOP controls into ID_EX; equals stall

## Operation
- The scoreboard has one entry per stage: {vld, reg, load}. Reset clears all vld.
- The scoreboard shifts every cycle: entry k moves to k+1, and the last entry is dropped.
- Entry 0 is loaded with {id_valid & id_wr_en & ~stall & ~id_flush, id_wr_reg, id_is_load}. A stalled or flushed ID inserts a bubble (vld = 0).
- For each used source, stage k matches when vld[k] and reg[k] == source.
- The lowest matching k wins (youngest producer); sel = k+1 and the operand is stage_data[k]. With no match, sel = 0 and the operand is the RF port.
- An unused source gives sel = 0 and never stalls.
- stall = id_valid & ~id_flush & any used source whose winning match is a load entry with k < LOAD_READY.
- An older match hidden behind a younger non-load match never stalls.
- Register index 15 (PC) is never matched: it always reads from the RF.

## Timing
- Selects, operands, stall and bubble are combinational from the scoreboard and ID inputs in the same cycle.
- The scoreboard updates on the rising edge of clk.
- Load-use penalty is LOAD_READY cycles. Defaults give 1 stall cycle, then forwarding from stage LOAD_READY.
- Reset asserted mid-operation clears the scoreboard immediately. All sel = 0, stall = 0, and operands follow the RF.
- Simultaneous stall and id_flush: flush wins, so stall = 0 and a bubble is inserted.

## Configuration
- HAZARD_STATS_EN defined adds two outputs:
  - stall_cnt [31:0] counts cycles with stall = 1.
  - fwd_cnt [31:0] counts cycles with any sel != 0.
  - Both saturate at all-ones, are cleared by R, and increment on the rising edge.
- Without the macro, neither the ports nor the counters exist.

## Structure
- Package hazard_pkg holds the stage index constants (STG_EX = 0, STG_MEM = 1, STG_WB = 2), PC_REG = 15, and the scoreboard entry typedef.
- Sub-module fwd_operand_mux performs the priority match plus data select for one source. It is instantiated three times (Rn, Rm, Rd) and reports sel, data and a load-not-ready flag.

## Test plan
- ADD R1 issued, next cycle SUB reads Rn = R1 -> fw_rn_sel = 1, op_a = stage_data[0] (set to 32'h0000_0005).
- LDR R2 issued, next cycle reads Rm = R2 -> stall = 1 and bubble = 1 for one cycle. The next cycle gives stall = 0 and fw_rm_sel = 2.
- R3 written at stage 0 and stage 2 simultaneously -> fw_rn_sel = 1 (youngest). Read Rn = R15 -> sel = 0, op_a = rf_pa.
- Producer issued with id_flush = 1 -> the following consumer of that register sees sel = 0 and stall = 0.
- Assert R while a load sits in entry 0 -> stall drops to 0 in the same cycle and the scoreboard is empty after release.
- HAZARD_STATS_EN with stall_cnt preloaded via force to 32'hFFFF_FFFE, then 3 stall cycles -> stall_cnt = 32'hFFFF_FFFF and holds.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and scoreboard entry type for the ID-stage hazard/forwarding unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: stage index constants, the PC register index, and the entry type
//           held per tracked post-decode stage.
package hazard_pkg;

   localparam int STG_EX  = 0;
   localparam int STG_MEM = 1;
   localparam int STG_WB  = 2;

   // The PC (R15) always reads from the register file and is never forwarded.
   localparam int PC_REG  = 15;

   // Destination field width in an entry. It must be at least RW. Narrower
   // indices are zero-extended, so unused upper bits are constant and trim away.
   localparam int SB_REG_W = 8;

   typedef struct packed {
      logic                vld;
      logic [SB_REG_W-1:0] dst;
      logic                load;
   } sb_entry_t;

endpackage

// File: rtl/fwd_operand_mux.sv
// Priority match of one ID source against the scoreboard, with operand select.
// Latency: purely combinational.
// Backpressure: none; load_nrdy_o feeds the stall decision in the parent.
// Ports: used_i/src_i      source enable and register index
//        sb_i              scoreboard entries, index 0 = youngest (EX)
//        stage_data_i      forwarded value per stage; rf_data_i is the RF read port
//        sel_o/data_o      0 = RF, k = stage k-1, plus the selected operand
//        load_nrdy_o       the winning producer is a load whose data is not yet available
module fwd_operand_mux
   import hazard_pkg::*;
#(
   parameter int DW         = 32,
   parameter int RW         = 4,
   parameter int STAGES     = 3,
   parameter int LOAD_READY = 1,
   parameter int SELW       = $clog2(STAGES + 1)
) (
   input  logic                   used_i,
   input  logic [RW-1:0]          src_i,
   input  sb_entry_t [STAGES-1:0] sb_i,
   input  logic [STAGES*DW-1:0]   stage_data_i,
   input  logic [DW-1:0]          rf_data_i,
   output logic [SELW-1:0]        sel_o,
   output logic [DW-1:0]          data_o,
   output logic                   load_nrdy_o
);

   logic can_match;

   always_comb begin
      sel_o       = '0;
      data_o      = rf_data_i;
      load_nrdy_o = 1'b0;
      can_match   = used_i && (src_i != RW'(PC_REG));
      // Walk from oldest to youngest so that the youngest match is assigned
      // last and wins. An older load hidden behind it therefore never stalls.
      for (int k = STAGES - 1; k >= 0; k--) begin
         if (can_match && sb_i[k].vld && (sb_i[k].dst == SB_REG_W'(src_i))) begin
            sel_o       = SELW'(k + 1);
            data_o      = stage_data_i[k*DW +: DW];
            load_nrdy_o = sb_i[k].load && (k < LOAD_READY);
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit: tracks in-flight register writes and picks operand sources in ID.
// Latency: selects, operands and stall are combinational; the scoreboard advances every clock.
// Backpressure: stall holds PC/IF_ID and bubble injects a NOP into ID_EX; a flush overrides stall.
// Ports: clk, R (async active-high reset); id_* describe the ID instruction;
//        rf_pa/pb/pd are RF read data; stage_data holds per-stage forwarded values;
//        op_a/b/d and fw_*_sel are the chosen operands and sources; stall and bubble are outputs.
// Option: HAZARD_STATS_EN adds the saturating counters stall_cnt and fwd_cnt.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int  DW         = 32,
   parameter int  RW         = 4,
   parameter int  STAGES     = 3,
   parameter int  LOAD_READY = 1,
   localparam int SELW       = $clog2(STAGES + 1)
) (
   input  logic                 clk,
   input  logic                 R,
   input  logic                 id_valid,
   input  logic                 id_flush,
   input  logic [RW-1:0]        id_rn,
   input  logic [RW-1:0]        id_rm,
   input  logic [RW-1:0]        id_rd,
   input  logic                 id_rn_used,
   input  logic                 id_rm_used,
   input  logic                 id_rd_used,
   input  logic                 id_wr_en,
   input  logic [RW-1:0]        id_wr_reg,
   input  logic                 id_is_load,
   input  logic [DW-1:0]        rf_pa,
   input  logic [DW-1:0]        rf_pb,
   input  logic [DW-1:0]        rf_pd,
   input  logic [STAGES*DW-1:0] stage_data,
   output logic [DW-1:0]        op_a,
   output logic [DW-1:0]        op_b,
   output logic [DW-1:0]        op_d,
   output logic [SELW-1:0]      fw_rn_sel,
   output logic [SELW-1:0]      fw_rm_sel,
   output logic [SELW-1:0]      fw_rd_sel,
   output logic                 stall,
   output logic                 bubble
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]          stall_cnt,
   output logic [31:0]          fwd_cnt
`endif
);

   sb_entry_t [STAGES-1:0] sb_q, sb_d;
   logic nrdy_a, nrdy_b, nrdy_d;

   fwd_operand_mux #(.DW(DW), .RW(RW), .STAGES(STAGES), .LOAD_READY(LOAD_READY), .SELW(SELW)) u_mux_rn (
      .used_i(id_rn_used), .src_i(id_rn), .sb_i(sb_q), .stage_data_i(stage_data),
      .rf_data_i(rf_pa), .sel_o(fw_rn_sel), .data_o(op_a), .load_nrdy_o(nrdy_a));

   fwd_operand_mux #(.DW(DW), .RW(RW), .STAGES(STAGES), .LOAD_READY(LOAD_READY), .SELW(SELW)) u_mux_rm (
      .used_i(id_rm_used), .src_i(id_rm), .sb_i(sb_q), .stage_data_i(stage_data),
      .rf_data_i(rf_pb), .sel_o(fw_rm_sel), .data_o(op_b), .load_nrdy_o(nrdy_b));

   fwd_operand_mux #(.DW(DW), .RW(RW), .STAGES(STAGES), .LOAD_READY(LOAD_READY), .SELW(SELW)) u_mux_rd (
      .used_i(id_rd_used), .src_i(id_rd), .sb_i(sb_q), .stage_data_i(stage_data),
      .rf_data_i(rf_pd), .sel_o(fw_rd_sel), .data_o(op_d), .load_nrdy_o(nrdy_d));

   // A flush overrides the stall, so a squashed instruction never holds the front end.
   assign stall  = id_valid & ~id_flush & (nrdy_a | nrdy_b | nrdy_d);
   assign bubble = stall;

   always_comb begin
      sb_d = '0;
      for (int k = STAGES - 1; k > 0; k--) begin
         sb_d[k] = sb_q[k-1];
      end
      // A stalled or flushed ID enters the pipe as a bubble.
      sb_d[STG_EX].vld  = id_valid & id_wr_en & ~stall & ~id_flush;
      sb_d[STG_EX].dst  = SB_REG_W'(id_wr_reg);
      sb_d[STG_EX].load = id_is_load;
   end

   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         sb_q <= '0;
      end else begin
         sb_q <= sb_d;
      end
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] fwd_cnt_q, fwd_cnt_d;
   logic        any_fwd;

   assign any_fwd = (fw_rn_sel != '0) | (fw_rm_sel != '0) | (fw_rd_sel != '0);

   // Both counters stick at all-ones instead of wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      fwd_cnt_d   = fwd_cnt_q;
      if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 32'd1;
      if (any_fwd && !(&fwd_cnt_q)) fwd_cnt_d = fwd_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard using directed cases and random issue streams.
// The reference model stores each issued write with its issue cycle and derives the stage from the instruction's age.
// Option: HAZARD_STATS_EN also exercises counter saturation.
module tb_hazard_scoreboard;

   localparam int DW         = 32;
   localparam int RW         = 4;
   localparam int STAGES     = 3;
   localparam int LOAD_READY = 1;
   localparam int SELW       = $clog2(STAGES + 1);

   logic                 clk = 1'b0;
   logic                 R;
   logic                 id_valid, id_flush;
   logic [RW-1:0]        id_rn, id_rm, id_rd, id_wr_reg;
   logic                 id_rn_used, id_rm_used, id_rd_used, id_wr_en, id_is_load;
   logic [DW-1:0]        rf_pa, rf_pb, rf_pd;
   logic [STAGES*DW-1:0] stage_data;
   logic [DW-1:0]        op_a, op_b, op_d;
   logic [SELW-1:0]      fw_rn_sel, fw_rm_sel, fw_rd_sel;
   logic                 stall, bubble;
`ifdef HAZARD_STATS_EN
   logic [31:0]          stall_cnt, fwd_cnt;
`endif

   hazard_scoreboard #(.DW(DW), .RW(RW), .STAGES(STAGES), .LOAD_READY(LOAD_READY)) dut (
      .clk(clk), .R(R), .id_valid(id_valid), .id_flush(id_flush),
      .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
      .id_rn_used(id_rn_used), .id_rm_used(id_rm_used), .id_rd_used(id_rd_used),
      .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_is_load(id_is_load),
      .rf_pa(rf_pa), .rf_pb(rf_pb), .rf_pd(rf_pd), .stage_data(stage_data),
      .op_a(op_a), .op_b(op_b), .op_d(op_d),
      .fw_rn_sel(fw_rn_sel), .fw_rm_sel(fw_rm_sel), .fw_rd_sel(fw_rd_sel),
      .stall(stall), .bubble(bubble)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: every recorded write with the cycle in which it left ID.
   int cyc = 0;
   int q_cyc[$];
   int q_reg[$];
   bit q_ld[$];
   bit exp_stall;
   logic [31:0] obs_sel_a, obs_sel_b, obs_op_a, obs_op_b, obs_stall, obs_bubble;

   function automatic void model_src(input bit used, input int src, output int sel, output bit nrdy);
      int best;
      bit bld;
      sel = 0;
      nrdy = 0;
      best = STAGES;
      bld = 0;
      if (!used || src == 15) return;
      foreach (q_cyc[i]) begin
         int age;
         age = cyc - q_cyc[i] - 1;
         if (age >= 0 && age < best && q_reg[i] == src) begin
            best = age;
            bld = q_ld[i];
         end
      end
      if (best < STAGES) begin
         sel = best + 1;
         nrdy = bld && (best < LOAD_READY);
      end
   endfunction

   function automatic logic [31:0] exp_op(input int sel, input logic [DW-1:0] rf);
      if (sel == 0) return rf;
      return stage_data[(sel-1)*DW +: DW];
   endfunction

   task automatic model_reset();
      q_cyc.delete();
      q_reg.delete();
      q_ld.delete();
   endtask

   task automatic rand_data();
      rf_pa = $urandom;
      rf_pb = $urandom;
      rf_pd = $urandom;
      for (int k = 0; k < STAGES; k++) stage_data[k*DW +: DW] = $urandom;
   endtask

   task automatic check_outputs(input string tag);
      int sa, sb, sd;
      bit na, nb, nd;
      model_src(id_rn_used, int'(id_rn), sa, na);
      model_src(id_rm_used, int'(id_rm), sb, nb);
      model_src(id_rd_used, int'(id_rd), sd, nd);
      exp_stall = id_valid && !id_flush && (na || nb || nd);
      chk({tag, ".sel_a"}, 32'(fw_rn_sel), sa);
      chk({tag, ".sel_b"}, 32'(fw_rm_sel), sb);
      chk({tag, ".sel_d"}, 32'(fw_rd_sel), sd);
      chk({tag, ".op_a"}, op_a, exp_op(sa, rf_pa));
      chk({tag, ".op_b"}, op_b, exp_op(sb, rf_pb));
      chk({tag, ".op_d"}, op_d, exp_op(sd, rf_pd));
      chk({tag, ".stall"}, 32'(stall), 32'(exp_stall));
      chk({tag, ".bubble"}, 32'(bubble), 32'(exp_stall));
      obs_sel_a = 32'(fw_rn_sel);
      obs_sel_b = 32'(fw_rm_sel);
      obs_op_a = op_a;
      obs_op_b = op_b;
      obs_stall = 32'(stall);
      obs_bubble = 32'(bubble);
   endtask

   task automatic advance();
      @(posedge clk);
      if (!R && id_valid && id_wr_en && !exp_stall && !id_flush) begin
         q_cyc.push_back(cyc);
         q_reg.push_back(int'(id_wr_reg));
         q_ld.push_back(id_is_load);
      end
      cyc++;
      while (q_cyc.size() > 0 && cyc - q_cyc[0] - 1 >= STAGES) begin
         void'(q_cyc.pop_front());
         void'(q_reg.pop_front());
         void'(q_ld.pop_front());
      end
      #1;
   endtask

   task automatic set_id(input int v, input int fl, input int rn, input int rm, input int rd,
                         input int use3, input int we, input int wr, input int ld);
      id_valid   = (v != 0);
      id_flush   = (fl != 0);
      id_rn      = RW'(rn);
      id_rm      = RW'(rm);
      id_rd      = RW'(rd);
      id_rn_used = use3[0];
      id_rm_used = use3[1];
      id_rd_used = use3[2];
      id_wr_en   = (we != 0);
      id_wr_reg  = RW'(wr);
      id_is_load = (ld != 0);
   endtask

   task automatic step(input string tag, input int v, input int fl, input int rn, input int rm,
                       input int rd, input int use3, input int we, input int wr, input int ld);
      set_id(v, fl, rn, rm, rd, use3, we, wr, ld);
      @(negedge clk);
      check_outputs(tag);
      advance();
   endtask

   function automatic int pick_reg();
      int r;
      r = $urandom_range(0, 5);
      return (r == 5) ? 15 : r;
   endfunction

   initial begin
      R = 1'b1;
      stage_data = '0;
      rand_data();
      set_id(1, 0, 1, 2, 3, 7, 1, 1, 1);
      #2;
      chk("reset.stall", 32'(stall), 32'd0);
      chk("reset.sel_a", 32'(fw_rn_sel), 32'd0);
      chk("reset.op_a", op_a, rf_pa);
      @(posedge clk);
      #1;
      R = 1'b0;
      model_reset();

      // ADD R1, then a consumer of R1 in the following cycle.
      rand_data();
      step("add", 1, 0, 2, 3, 0, 3, 1, 1, 0);
      rand_data();
      stage_data[31:0] = 32'h0000_0005;
      step("sub", 1, 0, 1, 4, 0, 3, 1, 5, 0);
      chk("tp.add_sel", obs_sel_a, 32'd1);
      chk("tp.add_op", obs_op_a, 32'h0000_0005);

      // LDR R2, then load-use on Rm: one stall cycle, then forwarding from MEM.
      rand_data();
      step("ldr", 1, 0, 7, 0, 0, 1, 1, 2, 1);
      rand_data();
      step("use1", 1, 0, 8, 2, 0, 2, 1, 9, 0);
      chk("tp.lu_stall", obs_stall, 32'd1);
      chk("tp.lu_bubble", obs_bubble, 32'd1);
      rand_data();
      step("use2", 1, 0, 8, 2, 0, 2, 1, 9, 0);
      chk("tp.lu_stall2", obs_stall, 32'd0);
      chk("tp.lu_sel", obs_sel_b, 32'd2);

      // R3 in EX and WB at once; R15 in flight must still read from the RF.
      rand_data();
      step("w3a", 1, 0, 0, 0, 0, 0, 1, 3, 0);
      step("w15", 1, 0, 0, 0, 0, 0, 1, 15, 0);
      step("w3b", 1, 0, 0, 0, 0, 0, 1, 3, 0);
      rand_data();
      step("r3", 1, 0, 3, 15, 0, 3, 0, 0, 0);
      chk("tp.young_sel", obs_sel_a, 32'd1);
      chk("tp.pc_sel", obs_sel_b, 32'd0);
      chk("tp.pc_op", obs_op_b, rf_pb);

      // Flushed producer leaves nothing behind.
      rand_data();
      step("flushp", 1, 1, 0, 0, 0, 0, 1, 10, 1);
      step("flushc", 1, 0, 10, 0, 0, 1, 0, 0, 0);
      chk("tp.flush_sel", obs_sel_a, 32'd0);
      chk("tp.flush_stall", obs_stall, 32'd0);

      // Asynchronous reset with a load in EX and its consumer in ID.
      rand_data();
      step("rldr", 1, 0, 0, 0, 0, 0, 1, 11, 1);
      set_id(1, 0, 11, 0, 0, 1, 0, 0, 0);
      #1;
      check_outputs("rstmid.pre");
      chk("tp.rst_pre_stall", obs_stall, 32'd1);
      R = 1'b1;
      model_reset();
      #1;
      check_outputs("rstmid.in");
      chk("tp.rst_in_stall", obs_stall, 32'd0);
      chk("tp.rst_in_op", obs_op_a, rf_pa);
      R = 1'b0;
      #1;
      check_outputs("rstmid.post");
      chk("tp.rst_post_sel", obs_sel_a, 32'd0);
      advance();

      // Random issue stream with a small register set to provoke overlaps.
      for (int i = 0; i < 400; i++) begin
         rand_data();
         step("rnd", ($urandom % 8) != 0, ($urandom % 8) == 0, pick_reg(), pick_reg(), pick_reg(),
              int'($urandom % 8), ($urandom % 4) != 0, pick_reg(), ($urandom % 3) == 0);
      end

`ifdef HAZARD_STATS_EN
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      for (int i = 0; i < 3; i++) begin
         rand_data();
         step("sldr", 1, 0, 0, 0, 0, 0, 1, 12, 1);
         step("suse", 1, 0, 12, 0, 0, 1, 0, 0, 0);
         chk("stat.stall", obs_stall, 32'd1);
      end
      chk("stat.sat", stall_cnt, 32'hFFFF_FFFF);
      step("shold", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("stat.hold", stall_cnt, 32'hFFFF_FFFF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
